// File: rtl/adder_out_buffer.sv
// adder_out_buffer: result-collection stage behind a fixed-latency pipelined adder.
// A valid delay line tracks which adder cycles carry a real operation. Results leaving
// the adder are captured into a small FIFO with a valid/ready output. A credit check
// (fifo_count + inflight < DEPTH) throttles upstream issue so the FIFO can never overflow.
// Optional feature: define ADDER_OUT_BUFFER_SEQ_EN to add an 8-bit issue tag (out_seq).
module adder_out_buffer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             issue_ready,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             cout_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             drop_err
`ifdef ADDER_OUT_BUFFER_SEQ_EN
  ,
  output logic [7:0]       out_seq
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned IW = $clog2(LATENCY + 1);
  localparam int unsigned SW = ((CW > IW) ? CW : IW) + 1;

  logic [LATENCY-1:0] vline;
  logic [IW-1:0]      inflight;
  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic [CW-1:0]      fifo_count;
  logic [WIDTH:0]     mem [DEPTH];
  logic [SW-1:0]      credit_used;
  logic               accept;
  logic               push;
  logic               pop;

  // Credit check and handshake decode.
  always_comb begin
    credit_used = SW'(fifo_count) + SW'(inflight);
    issue_ready = credit_used < SW'(DEPTH);
    accept      = in_valid & issue_ready;
    push        = vline[LATENCY-1];
    out_valid   = fifo_count != '0;
    pop         = out_valid & out_ready;
    out_sum     = out_valid ? mem[rptr][WIDTH-1:0] : '0;
    out_cout    = out_valid ? mem[rptr][WIDTH] : 1'b0;
  end

  // Valid delay line mirrors the adder pipeline; its tail marks a real result on sum_in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vline <= '0;
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        vline[i] <= vline[i-1];
      end
      vline[0] <= accept;
    end
  end

  // In-flight counter: operations accepted but not yet captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else if (accept && !push) begin
      inflight <= inflight + IW'(1);
    end else if (!accept && push) begin
      inflight <= inflight - IW'(1);
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      if (push && !pop) begin
        fifo_count <= fifo_count + CW'(1);
      end else if (!push && pop) begin
        fifo_count <= fifo_count - CW'(1);
      end
    end
  end

  // FIFO storage; no reset needed because outputs are gated to zero when empty.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {cout_in, sum_in};
  end

  // Sticky error: an operation was offered while credits were exhausted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_err <= 1'b0;
    end else if (in_valid && !issue_ready) begin
      drop_err <= 1'b1;
    end
  end

`ifdef ADDER_OUT_BUFFER_SEQ_EN
  logic [7:0] seq_cnt;
  logic [7:0] tline [LATENCY];
  logic [7:0] tmem  [DEPTH];

  // Issue tag counter and tag delay line travelling alongside the valid line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_cnt <= '0;
      for (int i = 0; i < LATENCY; i++) tline[i] <= '0;
    end else begin
      if (accept) seq_cnt <= seq_cnt + 8'd1;
      for (int i = LATENCY - 1; i > 0; i--) begin
        tline[i] <= tline[i-1];
      end
      tline[0] <= seq_cnt;
    end
  end

  // Tag storage written alongside the result.
  always_ff @(posedge clk) begin
    if (push) tmem[wptr] <= tline[LATENCY-1];
  end

  // Head tag, zero when empty.
  always_comb begin
    out_seq = out_valid ? tmem[rptr] : 8'd0;
  end
`endif

endmodule

// File: tb/tb_adder_out_buffer.sv
// Bench for adder_out_buffer: behavioural adder upstream, queue-based reference model,
// per-cycle compare process plus hand-computed literal checks.
// Define ADDER_OUT_BUFFER_SEQ_EN to also exercise the tag feature.
module tb_adder_out_buffer;

  localparam int WIDTH = 16;
  localparam int LAT   = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             issue_ready;
  logic [WIDTH-1:0] sum_in;
  logic             cout_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             drop_err;
  logic [7:0]       out_seq_w;

  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_c;
  logic [16:0] pipe [LAT];

  int checks   = 0;
  int failures = 0;
  int prints   = 0;
  bit seen106  = 0;

  always #5 clk = ~clk;

  adder_out_buffer #(.WIDTH(WIDTH), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .issue_ready(issue_ready),
    .sum_in     (sum_in),
    .cout_in    (cout_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_cout   (out_cout),
    .drop_err   (drop_err)
`ifdef ADDER_OUT_BUFFER_SEQ_EN
    ,
    .out_seq    (out_seq_w)
`endif
  );

`ifndef ADDER_OUT_BUFFER_SEQ_EN
  assign out_seq_w = 8'd0;
`endif

  // Upstream adder: fixed-latency pipeline, no reset (as a real datapath would be).
  always @(posedge clk) begin
    pipe[0] <= 17'(op_a) + 17'(op_b) + 17'(op_c);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {cout_in, sum_in} = pipe[LAT-1];

  // Reference model: in-flight queue with due cycles, FIFO queue of {tag, cout, sum}.
  typedef struct {
    int          due;
    logic [24:0] v;
  } fl_t;
  fl_t         m_fl[$];
  logic [24:0] m_fifo[$];
  bit          m_drop;
  logic [7:0]  m_seq;
  int          mcyc;

  function automatic bit m_ready();
    return (m_fifo.size() + m_fl.size()) < DEPTH;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_fl.delete();
      m_fifo.delete();
      m_drop = 0;
      m_seq  = 0;
      mcyc   = 0;
    end else begin
      bit rdy;
      fl_t e;
      rdy = m_ready();
      if (in_valid && !rdy) m_drop = 1;
      if (m_fifo.size() > 0 && out_ready) void'(m_fifo.pop_front());
      if (m_fl.size() > 0 && m_fl[0].due == mcyc) begin
        e = m_fl.pop_front();
        m_fifo.push_back(e.v);
      end
      if (in_valid && rdy) begin
        e.due = mcyc + LAT;
        e.v   = {m_seq, 17'(op_a) + 17'(op_b) + 17'(op_c)};
        m_fl.push_back(e);
        m_seq = m_seq + 8'd1;
      end
      mcyc++;
    end
  end

  task automatic cmp(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (prints < 40) begin
        prints++;
        $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
      end
    end
  endtask

  // Popped-tag log for the tag test.
  logic [7:0] popped_tags[$];

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    logic [24:0] hd;
    hd = (m_fifo.size() > 0) ? m_fifo[0] : 25'd0;
    cmp("out_valid",   32'(out_valid),   32'(m_fifo.size() > 0));
    cmp("out_sum",     32'(out_sum),     32'(hd[15:0]));
    cmp("out_cout",    32'(out_cout),    32'(hd[16]));
    cmp("issue_ready", 32'(issue_ready), 32'(m_ready()));
    cmp("drop_err",    32'(drop_err),    32'(m_drop));
`ifdef ADDER_OUT_BUFFER_SEQ_EN
    cmp("out_seq",     32'(out_seq_w),   32'(hd[24:17]));
`endif
    if (out_valid && out_sum == 16'd106) seen106 = 1;
    if (!reset && out_valid && out_ready) popped_tags.push_back(out_seq_w);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, int a, int b, bit c);
    in_valid = v;
    op_a     = 16'(a);
    op_b     = 16'(b);
    op_c     = c;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    drive(0, 0, 0, 0);
    #1;
    tick();
    tick();
    reset = 1'b0;
    cmp("rst_out_valid",   32'(out_valid),   32'd0);
    cmp("rst_out_sum",     32'(out_sum),     32'd0);
    cmp("rst_out_cout",    32'(out_cout),    32'd0);
    cmp("rst_issue_ready", 32'(issue_ready), 32'd1);
    cmp("rst_drop_err",    32'(drop_err),    32'd0);

    // Single issue at edge 1, result visible after edge 5, popped at edge 6.
    drive(1, 3, 8, 0);
    tick();
    drive(0, 0, 0, 0);
    tick(); tick(); tick();
    cmp("single_not_early", 32'(out_valid), 32'd0);
    tick();
    cmp("single_valid", 32'(out_valid), 32'd1);
    cmp("single_sum",   32'(out_sum),   32'd11);
    cmp("single_cout",  32'(out_cout),  32'd0);
    tick();
    cmp("single_popped", 32'(out_valid), 32'd0);

    // Back-to-back with out_ready high.
    drive(1, 3, 3, 0);  tick();
    drive(1, 7, 1, 0);  tick();
    drive(1, 5, 9, 0);  tick();
    drive(1, 13, 29, 0); tick();
    drive(0, 0, 0, 0);
    tick(); cmp("b2b_0", 32'(out_sum), 32'd6);
    tick(); cmp("b2b_1", 32'(out_sum), 32'd8);
    tick(); cmp("b2b_2", 32'(out_sum), 32'd14);
    tick(); cmp("b2b_3", 32'(out_sum), 32'd42);
    tick(); cmp("b2b_empty", 32'(out_valid), 32'd0);

    // Backpressure: fill to credit limit, then violate, then drain.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1, i, i, 0);
      tick();
    end
    drive(0, 0, 0, 0);
    cmp("bp_ready_low", 32'(issue_ready), 32'd0);
    tick(); tick(); tick(); tick();
    cmp("bp_full_valid", 32'(out_valid),   32'd1);
    cmp("bp_full_head",  32'(out_sum),     32'd2);
    cmp("bp_full_ready", 32'(issue_ready), 32'd0);
    drive(1, 500, 500, 1);
    tick();
    drive(0, 0, 0, 0);
    cmp("viol_drop_err", 32'(drop_err), 32'd1);
    cmp("viol_head",     32'(out_sum),  32'd2);
    tick();
    cmp("viol_held_head", 32'(out_sum), 32'd2);
    out_ready = 1'b1;
    tick(); cmp("drain_1", 32'(out_sum), 32'd4); cmp("drain_ready", 32'(issue_ready), 32'd1);
    tick(); cmp("drain_2", 32'(out_sum), 32'd6);
    tick(); cmp("drain_3", 32'(out_sum), 32'd8);
    tick(); cmp("drain_empty", 32'(out_valid), 32'd0);
    tick(); tick(); tick(); tick(); tick();
    cmp("viol_no_extra", 32'(out_valid), 32'd0);
    cmp("drop_sticky",   32'(drop_err),  32'd1);

    // Reset mid-flight discards the pending 13+93 result.
    drive(1, 13, 93, 0);
    tick();
    drive(0, 0, 0, 0);
    tick(); tick();
    reset = 1'b1;
    #1;
    cmp("midrst_valid", 32'(out_valid),   32'd0);
    cmp("midrst_ready", 32'(issue_ready), 32'd1);
    cmp("midrst_drop",  32'(drop_err),    32'd0);
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    cmp("midrst_no_106", 32'(seen106), 32'd0);

`ifdef ADDER_OUT_BUFFER_SEQ_EN
    // 257 tagged issues; tags must run 0..255 then wrap to 0.
    do_reset();
    popped_tags.delete();
    out_ready = 1'b1;
    begin
      int n = 0;
      int guard = 0;
      while (n < 257 && guard < 5000) begin
        if (m_ready()) begin
          drive(1, $urandom_range(0, 65535), $urandom_range(0, 65535), 1'($urandom));
          n++;
        end else begin
          drive(0, 0, 0, 0);
        end
        tick();
        guard++;
      end
      drive(0, 0, 0, 0);
      for (int i = 0; i < 12; i++) tick();
      cmp("seq_count", 32'(popped_tags.size()), 32'd257);
      if (popped_tags.size() == 257) begin
        cmp("seq_first", 32'(popped_tags[0]),   32'd0);
        cmp("seq_255",   32'(popped_tags[255]), 32'd255);
        cmp("seq_wrap",  32'(popped_tags[256]), 32'd0);
      end
    end
`endif

    // Randomized traffic, mostly respecting credits, occasional violations.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      bit want;
      want = ($urandom % 4) != 0;
      if (!m_ready() && ($urandom % 40) != 0) want = 0;
      drive(want, $urandom_range(0, 65535), $urandom_range(0, 65535), 1'($urandom));
      out_ready = ($urandom % 3) != 0;
      if (i == 1000) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      tick();
    end
    drive(0, 0, 0, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    cmp("final_empty", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
